mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data path width; legal values 32 or 64.
REQ-002 SHALL have parameter DEPTH, default 256, data memory depth in DATA_W words.
REQ-003 SHALL have parameter LATENCY, default 0, extra stall cycles per memory access; legal values 0..7.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset; asynchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1 bit: EX/MEM entry valid.
REQ-007 SHALL have port mem_read, input, 1 bit: load.
REQ-008 SHALL have port mem_write, input, 1 bit: store.
REQ-009 SHALL have port size, input, 2 bits: access size; 00 byte, 01 half, 10 word(32), 11 dword.
REQ-010 SHALL have port load_unsigned, input, 1 bit: zero-extend load (else sign-extend).
REQ-011 SHALL have port branch, input, 1 bit: conditional branch.
REQ-012 SHALL have port branch_ne, input, 1 bit: branch on not-equal.
REQ-013 SHALL have port jump, input, 1 bit: unconditional jump.
REQ-014 SHALL have port zero, input, 1 bit: ALU zero flag.
REQ-015 SHALL have port alu_result, input, DATA_W bits: byte address, or pass-through result.
REQ-016 SHALL have port store_data, input, DATA_W bits: Rt value; data in low bits.
REQ-017 SHALL have port branch_addr, input, 32 bits: branch target.
REQ-018 SHALL have port jump_addr, input, 32 bits: jump target.
REQ-019 SHALL have port stall, output, 1 bit: upstream holds all inputs stable while high.
REQ-020 SHALL have port pc_src, output, 1 bit: take redirect.
REQ-021 SHALL have port pc_src_addr, output, 32 bits: redirect target.
REQ-022 SHALL have port wb_valid, output, 1 bit: registered MEM/WB entry valid.
REQ-023 SHALL have port wb_data, output, DATA_W bits: registered load data or alu_result.
REQ-024 SHALL have port misalign_err, output, 1 bit: registered one-cycle error pulse.

Function
REQ-025 SHALL define an op as "mem op" when in_valid=1 and (mem_read or mem_write), and as misaligned when its address is not a multiple of its size, or when size=11 with DATA_W=32.
REQ-026 SHALL index memory by (alu_result / (DATA_W/8)) mod DEPTH; out-of-range addresses wrap, and memory contents are not reset.
REQ-027 SHALL run an FSM with states IDLE and WAIT, plus a 3-bit counter cnt.
REQ-028 SHALL, in IDLE with an aligned mem op and LATENCY>0: drive stall=1 combinationally, load cnt=LATENCY-1, and go to WAIT.
REQ-029 SHALL, in WAIT: drive stall=(cnt!=0); decrement cnt while it is nonzero; when cnt=0, retire the op and return to IDLE.
REQ-030 SHALL give an aligned mem op presented at cycle t exactly LATENCY stall cycles (t..t+LATENCY-1), retire it at the end of cycle t+LATENCY, and show wb_valid=1 in cycle t+LATENCY+1; with LATENCY=0 it SHALL never stall.
REQ-031 SHALL retire a non-mem op or a misaligned op in the cycle it is presented, never stalling for it.
REQ-032 SHALL perform a store once, only at retire, writing only the addressed byte lanes; store_data low bits are replicated to the selected lane.
REQ-033 SHALL treat mem_read=mem_write=1 as a store only, with wb_data=alu_result.
REQ-034 SHALL return a load as the addressed lane, sign- or zero-extended to DATA_W; word loads SHALL also extend when DATA_W=64.
REQ-035 SHALL, on retire: load wb_valid=1; load wb_data with load data for loads, else alu_result.
REQ-036 SHALL, for a misaligned op: perform no memory access; set wb_valid=0 and misalign_err=1 for one cycle.
REQ-037 SHALL, in a cycle with in_valid=0 and no op retiring: set wb_valid=0 and hold wb_data.
REQ-038 SHALL drive pc_src = in_valid & !stall & (jump | (branch & (zero ^ branch_ne))) combinationally.
REQ-039 SHALL drive pc_src_addr = jump ? jump_addr : branch_addr, so jump wins when both jump and branch are asserted.

Reset
REQ-040 SHALL, while rst_n=0: force FSM=IDLE, cnt=0, wb_valid=0, wb_data=0, misalign_err=0; stall and pc_src SHALL read 0 when in_valid=0.
REQ-041 SHALL abandon an op that is in WAIT when reset asserts; its pending store SHALL never be written.

Verification
REQ-042 SHALL cover: rst_n=0 with in_valid=0 -> stall=0, pc_src=0, wb_valid=0, wb_data=0, misalign_err=0.
REQ-043 SHALL cover, with LATENCY=2: sw 0xDEADBEEF to 0x10 at cycle t -> stall=1 in cycles t and t+1; wb_valid=1 at t+3; then lw 0x10 -> wb_data=0xDEADBEEF.
REQ-044 SHALL cover: sb 0x80 to 0x13 -> lb 0x13 gives 0xFFFFFF80; lbu 0x13 gives 0x00000080; lw 0x10 gives 0x80ADBEEF.
REQ-045 SHALL cover: lh at 0x11 -> misalign_err=1 for one cycle, wb_valid=0, stall=0, memory unchanged.
REQ-046 SHALL cover: branch=1, branch_ne=1, zero=0 -> pc_src=1 with pc_src_addr=branch_addr; with jump=1 added -> pc_src_addr=jump_addr.
REQ-047 SHALL cover: rst_n pulsed low in cycle t+1 of a sw to 0x10 (LATENCY=2) -> stall=0 immediately; a later lw 0x10 returns the old value.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// MEM-stage bundle: EX/MEM entry fields in; stall, PC redirect and MEM/WB result out.
interface mem_access_unit_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              mem_read;
  logic              mem_write;
  logic [1:0]        size;
  logic              load_unsigned;
  logic              branch;
  logic              branch_ne;
  logic              jump;
  logic              zero;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] store_data;
  logic [31:0]       branch_addr;
  logic [31:0]       jump_addr;
  logic              stall;
  logic              pc_src;
  logic [31:0]       pc_src_addr;
  logic              wb_valid;
  logic [DATA_W-1:0] wb_data;
  logic              misalign_err;

  modport master (
    output in_valid, mem_read, mem_write, size, load_unsigned,
    output branch, branch_ne, jump, zero,
    output alu_result, store_data, branch_addr, jump_addr,
    input  stall, pc_src, pc_src_addr, wb_valid, wb_data, misalign_err
  );

  modport slave (
    input  in_valid, mem_read, mem_write, size, load_unsigned,
    input  branch, branch_ne, jump, zero,
    input  alu_result, store_data, branch_addr, jump_addr,
    output stall, pc_src, pc_src_addr, wb_valid, wb_data, misalign_err
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM pipeline stage: byte-lane data memory with configurable access latency,
// load extension, misalignment detection and branch/jump redirect.
module mem_access_unit #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_access_unit_if.slave bus
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;
  localparam logic [2:0] CNT_INIT = 3'((LATENCY > 0) ? (LATENCY - 1) : 0);

  logic [0:0]        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              wb_valid_q, wb_valid_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              mem_op;
  logic              misaligned;
  logic              is_load;
  logic              retire;
  logic              stall_raw;
  logic              stall_o;
  logic              store_we;
  logic [OFF_W-1:0]  off;
  logic [DATA_W-1:0] word_addr;
  logic [IDX_W-1:0]  idx;
  logic [NB-1:0]     lane_mask;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rd_shift;
  logic [DATA_W-1:0] ld_data;

  assign mem_op    = bus.in_valid & (bus.mem_read | bus.mem_write);
  assign is_load   = bus.mem_read & ~bus.mem_write;
  assign off       = bus.alu_result[OFF_W-1:0];
  assign word_addr = bus.alu_result >> OFF_W;
  assign idx       = IDX_W'(word_addr % DATA_W'(DEPTH));

  // A doubleword access can never be legal on a 32-bit data path.
  always_comb begin
    case (bus.size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = bus.alu_result[0];
      2'b10:   misaligned = |bus.alu_result[1:0];
      default: misaligned = (DATA_W == 32) || (|bus.alu_result[2:0]);
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_raw = 1'b0;
    retire    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_op && !misaligned && (LATENCY > 0)) begin
          stall_raw = 1'b1;
          cnt_d     = CNT_INIT;
          state_d   = S_WAIT;
        end else begin
          retire = bus.in_valid;
        end
      end
      default: begin
        stall_raw = (cnt_q != 3'd0);
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          retire  = 1'b1;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // Reset drops the stall at once so an in-flight access is visibly abandoned.
  assign stall_o = stall_raw & rst_n;

  always_comb begin
    case (bus.size)
      2'b00: begin
        lane_mask = NB'(1) << off;
        wdata     = {NB{bus.store_data[7:0]}};
      end
      2'b01: begin
        lane_mask = NB'(3) << off;
        wdata     = {(NB/2){bus.store_data[15:0]}};
      end
      2'b10: begin
        lane_mask = NB'(4'hF) << off;
        wdata     = {(NB/4){bus.store_data[31:0]}};
      end
      default: begin
        lane_mask = '1;
        wdata     = bus.store_data;
      end
    endcase
  end

  assign store_we = rst_n & retire & mem_op & ~misaligned & bus.mem_write;

  always_ff @(posedge clk) begin
    if (store_we) begin
      for (int b = 0; b < NB; b++) begin
        if (lane_mask[b]) begin
          mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    rd_shift = mem[idx] >> {off, 3'b000};
    case (bus.size)
      2'b00: ld_data = bus.load_unsigned ? DATA_W'(rd_shift[7:0])
                                         : DATA_W'($signed(rd_shift[7:0]));
      2'b01: ld_data = bus.load_unsigned ? DATA_W'(rd_shift[15:0])
                                         : DATA_W'($signed(rd_shift[15:0]));
      2'b10: ld_data = bus.load_unsigned ? DATA_W'(rd_shift[31:0])
                                         : DATA_W'($signed(rd_shift[31:0]));
      default: ld_data = rd_shift;
    endcase
  end

  always_comb begin
    wb_valid_d = 1'b0;
    wb_data_d  = wb_data_q;
    err_d      = 1'b0;
    if (retire) begin
      if (mem_op && misaligned) begin
        err_d = 1'b1;
      end else begin
        wb_valid_d = 1'b1;
        wb_data_d  = (mem_op && is_load) ? ld_data : bus.alu_result;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 3'd0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      err_q      <= err_d;
    end
  end

  assign bus.stall        = stall_o;
  assign bus.pc_src       = bus.in_valid & ~stall_o &
                            (bus.jump | (bus.branch & (bus.zero ^ bus.branch_ne)));
  assign bus.pc_src_addr  = bus.jump ? bus.jump_addr : bus.branch_addr;
  assign bus.wb_valid     = wb_valid_q;
  assign bus.wb_data      = wb_data_q;
  assign bus.misalign_err = err_q;

endmodule
